// File: rtl/dac_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// dac_cmd_scheduler
//
// Arbitrates DAC commands from two requesters (req0 = decoder command path,
// req1 = CPU/buffer path), holds the DAC target level, ramps the 12-bit DAC
// code toward it at a programmable rate and logs every granted command as a
// 25-bit record.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               synchronous reset, ACTIVE HIGH (1 = reset asserted)
//   reqN_valid/cmd/amount/ready
//                       command handshake per requester (N = 0, 1)
//   dac_out, dac_en     DAC code and output enable
//   busy                ramp (or shutdown ramp) in progress
//   no_order            one-cycle pulse when a granted opcode is invalid
//   log_valid/log_data/log_ready
//                       log record handshake toward the log FIFO
//
// Log record: [24] source, [23:21] opcode, [20] accepted, [19:12] amount,
//             [11:0] target after the command.
// ---------------------------------------------------------------------------

// Per-requester handshake gate: a requester sees ready only while the
// scheduler is open for commands and it holds the grant.
module dac_cmd_req_lane #(
    parameter int IDX = 0
) (
    input  logic grant_any,
    input  logic grant_idx,
    input  logic open,
    input  logic valid,
    output logic ready,
    output logic fire
);
    assign ready = open && grant_any && (grant_idx == 1'(IDX));
    assign fire  = ready && valid;
endmodule

module dac_cmd_scheduler #(
    parameter int RAMP_DIV  = 4,
    parameter int RAMP_STEP = 64,
    parameter int AMT_SCALE = 16,
    parameter int LOG_WIDTH = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [2:0]           req0_cmd,
    input  logic [7:0]           req0_amount,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [2:0]           req1_cmd,
    input  logic [7:0]           req1_amount,
    output logic                 req1_ready,
    output logic [11:0]          dac_out,
    output logic                 dac_en,
    output logic                 busy,
    output logic                 no_order,
    output logic                 log_valid,
    output logic [LOG_WIDTH-1:0] log_data,
    input  logic                 log_ready
);
    localparam int NUM_REQ = 2;
    localparam int TICK_W  = $clog2(RAMP_DIV);

    localparam logic [2:0]  OP_ON  = 3'd1;
    localparam logic [2:0]  OP_OFF = 3'd2;
    localparam logic [2:0]  OP_INC = 3'd3;
    localparam logic [2:0]  OP_DEC = 3'd4;

    localparam logic [11:0]       STEP_MAX  = 12'(RAMP_STEP);
    localparam logic [12:0]       SCALE     = 13'(AMT_SCALE);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2,
        S_SHUT = 2'd3
    } state_t;

    typedef struct packed {
        logic        src;
        logic [2:0]  op;
        logic        acc;
        logic [7:0]  amt;
        logic [11:0] tgt;
    } log_rec_t;

    // ---------------- state ----------------
    state_t              state, state_n;
    logic [11:0]         target, target_n;
    logic [11:0]         dac_n;
    logic [TICK_W-1:0]   tick, tick_n;
    logic                last_grant, last_n;
    logic                no_order_n;
    logic                log_valid_n;
    logic [LOG_WIDTH-1:0] log_data_n;

    // ---------------- requester packing ----------------
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][2:0]   req_cmd;
    logic [NUM_REQ-1:0][7:0]   req_amount;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_fire;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_cmd    = {req1_cmd, req0_cmd};
    assign req_amount = {req1_amount, req0_amount};
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // ---------------- arbitration ----------------
    logic grant_any, grant_idx, open, hs;
    logic [2:0] cmd_sel;
    logic [7:0] amt_sel;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_any = |req_valid;
        if (&req_valid) grant_idx = ~last_grant;
        else            grant_idx = req_valid[1];
    end

    // Commands are only taken while idle (OFF/HOLD) and the log slot is free.
    assign open = ((state == S_OFF) || (state == S_HOLD)) && !log_valid && !rst_n;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        dac_cmd_req_lane #(.IDX(i)) u_lane (
            .grant_any (grant_any),
            .grant_idx (grant_idx),
            .open      (open),
            .valid     (req_valid[i]),
            .ready     (req_ready[i]),
            .fire      (req_fire[i])
        );
    end

    assign hs      = |req_fire;
    assign cmd_sel = req_cmd[grant_idx];
    assign amt_sel = req_amount[grant_idx];

    // ---------------- target arithmetic ----------------
    // 13-bit intermediates: bit 12 flags overflow on INC and borrow on DEC,
    // which turns into saturation at 4095 / 0 instead of wrapping.
    logic [12:0] scaled, inc_sum, dec_diff;
    logic [11:0] inc_tgt, dec_tgt;

    always_comb begin
        scaled   = {5'b0, amt_sel} * SCALE;
        inc_sum  = {1'b0, target} + scaled;
        dec_diff = {1'b0, target} - scaled;
        inc_tgt  = inc_sum[12]  ? 12'hFFF : inc_sum[11:0];
        dec_tgt  = dec_diff[12] ? 12'h000 : dec_diff[11:0];
    end

    // ---------------- ramp datapath ----------------
    logic        ramp_up;
    logic [11:0] gap, step, dac_stepped;
    logic        tick_last;

    always_comb begin
        ramp_up     = target > dac_out;
        gap         = ramp_up ? (target - dac_out) : (dac_out - target);
        step        = (gap > STEP_MAX) ? STEP_MAX : gap;
        dac_stepped = ramp_up ? (dac_out + step) : (dac_out - step);
        tick_last   = (tick == TICK_LAST);
    end

    // ---------------- next state / outputs ----------------
    logic     acc;
    log_rec_t rec;

    always_comb begin
        state_n     = state;
        target_n    = target;
        dac_n       = dac_out;
        tick_n      = tick;
        last_n      = last_grant;
        no_order_n  = 1'b0;
        log_valid_n = log_valid;
        log_data_n  = log_data;
        acc         = 1'b1;
        rec         = '0;

        // Record is consumed; the data register simply keeps its last value.
        if (log_valid && log_ready) log_valid_n = 1'b0;

        case (state)
            S_RAMP, S_SHUT: begin
                if (tick_last) begin
                    tick_n = '0;
                    dac_n  = dac_stepped;
                    // Leave the ramp on the same edge the code lands on target.
                    if (dac_stepped == target)
                        state_n = (state == S_RAMP) ? S_HOLD : S_OFF;
                end else begin
                    tick_n = tick + TICK_W'(1);
                end
            end
            default: begin
                if (hs) begin
                    last_n      = grant_idx;
                    log_valid_n = 1'b1;
                    case (cmd_sel)
                        OP_ON: begin
                            if (state == S_OFF) begin
                                state_n = (dac_out == target) ? S_HOLD : S_RAMP;
                                tick_n  = '0;
                            end
                        end
                        OP_OFF: begin
                            target_n = '0;
                            if (state == S_HOLD) begin
                                state_n = S_SHUT;
                                tick_n  = '0;
                            end
                        end
                        OP_INC, OP_DEC: begin
                            target_n = (cmd_sel == OP_INC) ? inc_tgt : dec_tgt;
                            if ((state == S_HOLD) && (target_n != dac_out)) begin
                                state_n = S_RAMP;
                                tick_n  = '0;
                            end
                        end
                        default: begin
                            acc        = 1'b0;
                            no_order_n = 1'b1;
                        end
                    endcase
                    rec.src    = grant_idx;
                    rec.op     = cmd_sel;
                    rec.acc    = acc;
                    rec.amt    = amt_sel;
                    rec.tgt    = target_n;
                    log_data_n = LOG_WIDTH'(rec);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_OFF;
            target     <= '0;
            dac_out    <= '0;
            tick       <= '0;
            last_grant <= 1'b1;
            no_order   <= 1'b0;
            log_valid  <= 1'b0;
            log_data   <= '0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            dac_out    <= dac_n;
            tick       <= tick_n;
            last_grant <= last_n;
            no_order   <= no_order_n;
            log_valid  <= log_valid_n;
            log_data   <= log_data_n;
        end
    end

    assign dac_en = (state != S_OFF);
    assign busy   = (state == S_RAMP) || (state == S_SHUT);

endmodule

// File: tb/tb_dac_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dac_cmd_scheduler
//
// Directed table of single commands from a known state, hand-written
// sequences for ramp, shutdown, log back-pressure and reset, then a long
// randomized run checked each cycle against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_dac_cmd_scheduler;
    localparam int RAMP_DIV  = 4;
    localparam int RAMP_STEP = 64;
    localparam int AMT_SCALE = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_cmd, req1_cmd;
    logic [7:0]  req0_amount, req1_amount;
    logic        req0_ready, req1_ready;
    logic [11:0] dac_out;
    logic        dac_en, busy, no_order, log_valid, log_ready;
    logic [24:0] log_data;

    always #5 clk = ~clk;

    dac_cmd_scheduler #(
        .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP), .AMT_SCALE(AMT_SCALE), .LOG_WIDTH(25)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_amount(req0_amount), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_amount(req1_amount), .req1_ready(req1_ready),
        .dac_out(dac_out), .dac_en(dac_en), .busy(busy), .no_order(no_order),
        .log_valid(log_valid), .log_data(log_data), .log_ready(log_ready)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input int src, input logic [2:0] c, input logic [7:0] a);
        @(negedge clk);
        if (src == 0) begin req0_valid = 1'b1; req0_cmd = c; req0_amount = a; end
        else          begin req1_valid = 1'b1; req1_cmd = c; req1_amount = a; end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
    endtask

    typedef struct {
        logic        v0; logic [2:0] c0; logic [7:0] a0;
        logic        v1; logic [2:0] c1; logic [7:0] a1;
        logic [24:0] exp_log;
        logic        exp_no;
        logic        exp_en;
    } vec_t;

    vec_t tbl[12];

    // Watchdog: the run is fixed length, this only guards against a stuck sim.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // model state
    localparam int M_OFF = 0, M_RAMP = 1, M_HOLD = 2, M_SHUT = 3;
    int          m_mode, m_dac, m_tgt, m_last, m_step_at;
    logic        m_lv, m_no;
    logic [24:0] m_log;

    int          g, diff, st, tmp;
    logic        open, er0, er1, acc;
    logic [2:0]  c;
    logic [7:0]  a;
    logic [24:0] el;
    logic [1:0]  exp_rdy;

    initial begin
        // tie -> req0 first (last_grant resets to 1), then alternate
        tbl[0]  = '{1'b1, 3'd3, 8'd1,   1'b1, 3'd3, 8'd2,   25'h0701010, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd3, 8'd1,   1'b1, 3'd3, 8'd2,   25'h1702030, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'd3, 8'd1,   1'b1, 3'd3, 8'd2,   25'h0701040, 1'b0, 1'b0};
        // saturation at 4095 (64 + 4080 -> 4095, then stays)
        tbl[3]  = '{1'b1, 3'd3, 8'd255, 1'b0, 3'd0, 8'd0,   25'h07FFFFF, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'd3, 8'd255, 1'b0, 3'd0, 8'd0,   25'h07FFFFF, 1'b0, 1'b0};
        // invalid opcode 6 from req1: target unchanged
        tbl[5]  = '{1'b0, 3'd0, 8'd0,   1'b1, 3'd6, 8'd5,   25'h1C05FFF, 1'b1, 1'b0};
        // DEC 4095-4080 = 15, then 15-16 clamps to 0
        tbl[6]  = '{1'b0, 3'd0, 8'd0,   1'b1, 3'd4, 8'd255, 25'h19FF00F, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'd4, 8'd1,   1'b0, 3'd0, 8'd0,   25'h0901000, 1'b0, 1'b0};
        // OFF while OFF is accepted, NOP is not
        tbl[8]  = '{1'b1, 3'd2, 8'd0,   1'b0, 3'd0, 8'd0,   25'h0500000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 8'd0,   1'b1, 3'd0, 8'd3,   25'h1003000, 1'b1, 1'b0};
        // ON with dac==target goes straight to HOLD; then opcode 7 in HOLD
        tbl[10] = '{1'b1, 3'd1, 8'd0,   1'b0, 3'd0, 8'd0,   25'h0300000, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 3'd7, 8'd0,   1'b0, 3'd0, 8'd0,   25'h0E00000, 1'b1, 1'b1};

        rst_n = 1'b1; log_ready = 1'b1;
        req0_valid = 1'b1; req0_cmd = 3'd1; req0_amount = 8'd0;
        req1_valid = 1'b1; req1_cmd = 3'd1; req1_amount = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("rst_dac", dac_out, 0);
        check("rst_en_busy", {30'd0, dac_en, busy}, 0);
        check("rst_log", {6'd0, log_valid, log_data}, 0);
        check("rst_no_order", no_order, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req0_valid = tbl[i].v0; req0_cmd = tbl[i].c0; req0_amount = tbl[i].a0;
            req1_valid = tbl[i].v1; req1_cmd = tbl[i].c1; req1_amount = tbl[i].a1;
            #1;
            el = tbl[i].exp_log;
            exp_rdy = el[24] ? 2'b10 : 2'b01;
            check("tbl_ready", {30'd0, req1_ready, req0_ready}, {30'd0, exp_rdy});
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
            check("tbl_log_valid", log_valid, 1);
            check("tbl_log_data", log_data, el);
            check("tbl_no_order", no_order, tbl[i].exp_no);
            check("tbl_dac_en", dac_en, tbl[i].exp_en);
            check("tbl_dac_out", dac_out, 0);
            @(posedge clk);
        end

        // ---------------- ramp up: HOLD@0, INC 10 -> 160 ----------------
        @(negedge clk);
        req0_valid = 1'b1; req0_cmd = 3'd3; req0_amount = 8'd10;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 2) begin req1_valid = 1'b1; req1_cmd = 3'd3; req1_amount = 8'd1; end
            #1;
            if (k == 1) check("up_log", log_data, 25'h070A0A0);
            check("up_dac", dac_out, (k < 5) ? 0 : (k < 9) ? 64 : (k < 13) ? 128 : 160);
            check("up_busy", busy, (k < 13) ? 1 : 0);
            if (k >= 2 && k <= 10) check("up_ready", {30'd0, req1_ready, req0_ready}, 0);
            if (k == 10) req1_valid = 1'b0;
        end

        // ---------------- shutdown with log back-pressure ----------------
        @(negedge clk);
        log_ready = 1'b0;
        req0_valid = 1'b1; req0_cmd = 3'd2; req0_amount = 8'd0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin req1_valid = 1'b1; req1_cmd = 3'd3; req1_amount = 8'd1; end
            #1;
            if (k <= 5) begin
                check("stall_log_valid", log_valid, 1);
                check("stall_log_data", log_data, 25'h0500000);
                check("stall_ready", {30'd0, req1_ready, req0_ready}, 0);
            end
            check("shut_dac", dac_out, (k < 5) ? 160 : (k < 9) ? 96 : (k < 13) ? 32 : 0);
            check("shut_en", dac_en, (k < 13) ? 1 : 0);
            if (k == 5) begin log_ready = 1'b1; req1_valid = 1'b0; end
        end

        // ---------------- reset mid-ramp ----------------
        send(0, 3'd3, 8'd20);
        send(0, 3'd1, 8'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rr_dac", dac_out, 0);
        check("rr_en_busy", {30'd0, dac_en, busy}, 0);
        check("rr_ready", {30'd0, req1_ready, req0_ready}, 0);
        check("rr_log", {6'd0, log_valid, log_data}, 0);
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // ---------------- reset while a log record is pending ----------------
        log_ready = 1'b0;
        send(1, 3'd5, 8'd9);
        @(negedge clk);
        check("pend_log_valid", log_valid, 1);
        check("pend_log_data", log_data, 25'h1A09000);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pend_rst_log", {6'd0, log_valid, log_data}, 0);
        check("pend_rst_no", no_order, 0);
        rst_n = 1'b0; log_ready = 1'b1;

        // ---------------- randomized run against the model ----------------
        m_mode = M_OFF; m_dac = 0; m_tgt = 0; m_last = 1; m_step_at = 0;
        m_lv = 1'b0; m_no = 1'b0; m_log = '0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n       = (i == 0) || ($urandom_range(0, 299) == 0);
            req0_valid  = 1'($urandom_range(0, 1));
            req1_valid  = 1'($urandom_range(0, 1));
            req0_cmd    = 3'($urandom_range(0, 7));
            req1_cmd    = 3'($urandom_range(0, 7));
            req0_amount = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            req1_amount = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            log_ready   = ($urandom_range(0, 9) < 7);
            #1;
            open = ((m_mode == M_OFF) || (m_mode == M_HOLD)) && !m_lv && !rst_n;
            if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
            else                          g = -1;
            er0 = open && (g == 0);
            er1 = open && (g == 1);
            if (i > 0) begin
                check("rnd_ready0", req0_ready, er0);
                check("rnd_ready1", req1_ready, er1);
                check("rnd_dac", dac_out, m_dac);
                check("rnd_en", dac_en, (m_mode != M_OFF));
                check("rnd_busy", busy, (m_mode == M_RAMP) || (m_mode == M_SHUT));
                check("rnd_no_order", no_order, m_no);
                check("rnd_log_valid", log_valid, m_lv);
                check("rnd_log_data", log_data, m_log);
            end
            if (rst_n) begin
                m_mode = M_OFF; m_dac = 0; m_tgt = 0; m_last = 1;
                m_lv = 1'b0; m_no = 1'b0; m_log = '0;
            end else begin
                m_no = 1'b0;
                if (m_lv && log_ready) m_lv = 1'b0;
                if ((m_mode == M_RAMP || m_mode == M_SHUT) && i == m_step_at) begin
                    diff = m_tgt - m_dac;
                    st = (diff < 0) ? -diff : diff;
                    if (st > RAMP_STEP) st = RAMP_STEP;
                    m_dac = m_dac + ((diff < 0) ? -st : st);
                    if (m_dac == m_tgt) m_mode = (m_mode == M_RAMP) ? M_HOLD : M_OFF;
                    else                m_step_at = m_step_at + RAMP_DIV;
                end else if (er0 || er1) begin
                    c = (g == 0) ? req0_cmd : req1_cmd;
                    a = (g == 0) ? req0_amount : req1_amount;
                    m_last = g;
                    acc = 1'b1;
                    case (c)
                        3'd1: if (m_mode == M_OFF) begin
                            if (m_dac == m_tgt) m_mode = M_HOLD;
                            else begin m_mode = M_RAMP; m_step_at = i + RAMP_DIV; end
                        end
                        3'd2: begin
                            m_tgt = 0;
                            if (m_mode == M_HOLD) begin m_mode = M_SHUT; m_step_at = i + RAMP_DIV; end
                        end
                        3'd3, 3'd4: begin
                            tmp = (c == 3'd3) ? m_tgt + int'(a) * AMT_SCALE : m_tgt - int'(a) * AMT_SCALE;
                            m_tgt = (tmp > 4095) ? 4095 : (tmp < 0) ? 0 : tmp;
                            if (m_mode == M_HOLD && m_tgt != m_dac) begin
                                m_mode = M_RAMP; m_step_at = i + RAMP_DIV;
                            end
                        end
                        default: begin acc = 1'b0; m_no = 1'b1; end
                    endcase
                    m_log = {1'(g), c, acc, a, 12'(m_tgt)};
                    m_lv = 1'b1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
